// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: walks filter x kernel x row indices under a valid/ready
// handshake with the weight buffer, driving a one-hot PE select plus the
// kernel/row indices of the beat being loaded.
// Optional feature: define PE_BCAST_EN to add the bcast input, which loads all
// target PEs at once and runs the filter loop a single time.
module pe_load_sequencer #(
  parameter int unsigned MAX_FILTERNUM   = 64,
  parameter int unsigned MAX_KERNELNUM   = 8,
  parameter int unsigned MAX_ROW_NUM     = 8,
  parameter int unsigned FILTERNUM_WIDTH = $clog2(MAX_FILTERNUM) + 1,
  parameter int unsigned KERNELNUM_WIDTH = $clog2(MAX_KERNELNUM) + 1,
  parameter int unsigned ROWNUM_WIDTH    = $clog2(MAX_ROW_NUM) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [FILTERNUM_WIDTH-1:0] num_filter,
  input  logic [KERNELNUM_WIDTH-1:0] num_kernel,
  input  logic [ROWNUM_WIDTH-1:0]    num_row,
`ifdef PE_BCAST_EN
  input  logic                       bcast,
`endif
  input  logic                       w_valid,
  output logic                       w_ready,
  output logic [MAX_FILTERNUM-1:0]   filter_addr,
  output logic [KERNELNUM_WIDTH-1:0] kernel_idx,
  output logic [ROWNUM_WIDTH-1:0]    row_idx,
  output logic                       filter_load,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [FILTERNUM_WIDTH-1:0] MAX_F = FILTERNUM_WIDTH'(MAX_FILTERNUM);
  localparam logic [KERNELNUM_WIDTH-1:0] MAX_K = KERNELNUM_WIDTH'(MAX_KERNELNUM);
  localparam logic [ROWNUM_WIDTH-1:0]    MAX_R = ROWNUM_WIDTH'(MAX_ROW_NUM);
  localparam logic [MAX_FILTERNUM-1:0]   ONE   = MAX_FILTERNUM'(1);

  state_t                     state;
  logic [FILTERNUM_WIDTH-1:0] nf_q;
  logic [KERNELNUM_WIDTH-1:0] nk_q;
  logic [ROWNUM_WIDTH-1:0]    nr_q;
  logic [FILTERNUM_WIDTH-1:0] f_q;

  logic                       cfg_bad_c;
  logic [MAX_FILTERNUM-1:0]   bcast_mask_c;
  logic                       r_wrap_c;
  logic                       k_wrap_c;
  logic                       last_c;
  logic [ROWNUM_WIDTH-1:0]    r_next_c;
  logic [KERNELNUM_WIDTH-1:0] k_next_c;
  logic [FILTERNUM_WIDTH-1:0] f_next_c;
  logic                       bcast_in_c;
  logic                       bcast_q;

`ifdef PE_BCAST_EN
  assign bcast_in_c = bcast;

  // Broadcast mode is captured with the counts when a sequence starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcast_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      bcast_q <= bcast;
    end
  end
`else
  assign bcast_in_c = 1'b0;
  assign bcast_q    = 1'b0;
`endif

  // Configuration check and all-targets mask, evaluated on the live count inputs.
  always_comb begin
    cfg_bad_c    = (num_filter == '0) || (num_kernel == '0) || (num_row == '0) ||
                   (num_filter > MAX_F) || (num_kernel > MAX_K) || (num_row > MAX_R);
    // A shift by the full width yields zero, so num_filter == MAX gives all ones.
    bcast_mask_c = (ONE << num_filter) - ONE;
  end

  // Next counter values for an accepted beat: row innermost, filter outermost.
  always_comb begin
    r_wrap_c = (row_idx == nr_q - ROWNUM_WIDTH'(1));
    k_wrap_c = (kernel_idx == nk_q - KERNELNUM_WIDTH'(1));
    last_c   = r_wrap_c && k_wrap_c && (bcast_q || (f_q == nf_q - FILTERNUM_WIDTH'(1)));
    r_next_c = r_wrap_c ? '0 : row_idx + ROWNUM_WIDTH'(1);
    k_next_c = kernel_idx;
    f_next_c = f_q;
    if (r_wrap_c) begin
      k_next_c = k_wrap_c ? '0 : kernel_idx + KERNELNUM_WIDTH'(1);
      if (k_wrap_c) begin
        f_next_c = f_q + FILTERNUM_WIDTH'(1);
      end
    end
  end

  // Sequencer FSM with registered outputs; kernel_idx/row_idx double as the k/r counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      nf_q        <= '0;
      nk_q        <= '0;
      nr_q        <= '0;
      f_q         <= '0;
      filter_addr <= '0;
      kernel_idx  <= '0;
      row_idx     <= '0;
      w_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      filter_load <= 1'b1;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            nf_q       <= num_filter;
            nk_q       <= num_kernel;
            nr_q       <= num_row;
            f_q        <= '0;
            kernel_idx <= '0;
            row_idx    <= '0;
            if (cfg_bad_c) begin
              state   <= S_DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end else begin
              state       <= S_LOAD;
              w_ready     <= 1'b1;
              busy        <= 1'b1;
              filter_load <= 1'b0;
              filter_addr <= bcast_in_c ? bcast_mask_c : ONE;
            end
          end
        end
        S_LOAD: begin
          if (w_valid && w_ready) begin
            if (last_c) begin
              state       <= S_DONE;
              done        <= 1'b1;
              w_ready     <= 1'b0;
              busy        <= 1'b0;
              filter_load <= 1'b1;
              filter_addr <= '0;
              kernel_idx  <= '0;
              row_idx     <= '0;
            end else begin
              row_idx    <= r_next_c;
              kernel_idx <= k_next_c;
              f_q        <= f_next_c;
              if (!bcast_q) begin
                filter_addr <= ONE << f_next_c;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Self-checking bench for pe_load_sequencer: randomized runs against a
// queue-based model of the expected beat sequence.
module tb_pe_load_sequencer;

  localparam int unsigned MF = 64;
  localparam int unsigned FW = 7;
  localparam int unsigned KW = 4;
  localparam int unsigned RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [FW-1:0] num_filter;
  logic [KW-1:0] num_kernel;
  logic [RW-1:0] num_row;
`ifdef PE_BCAST_EN
  logic          bcast;
`endif
  logic          w_valid;
  logic          w_ready;
  logic [MF-1:0] filter_addr;
  logic [KW-1:0] kernel_idx;
  logic [RW-1:0] row_idx;
  logic          filter_load;
  logic          busy;
  logic          done;
  logic          cfg_err;

  typedef struct packed {
    logic [MF-1:0] addr;
    logic [KW-1:0] k;
    logic [RW-1:0] r;
  } beat_t;

  beat_t exp_q[$];
  int    passed = 0;
  int    total  = 0;

  pe_load_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_filter  (num_filter),
    .num_kernel  (num_kernel),
    .num_row     (num_row),
`ifdef PE_BCAST_EN
    .bcast       (bcast),
`endif
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .filter_addr (filter_addr),
    .kernel_idx  (kernel_idx),
    .row_idx     (row_idx),
    .filter_load (filter_load),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; w_valid = 1'b0;
    num_filter = '0; num_kernel = '0; num_row = '0;
`ifdef PE_BCAST_EN
    bcast = 1'b0;
`endif
    repeat (2) @(negedge clk);
    total++; if (filter_addr !== '0) $display("FAIL reset_addr got %h want 0", filter_addr); else passed++;
    total++; if (kernel_idx !== '0) $display("FAIL reset_k got %0d want 0", kernel_idx); else passed++;
    total++; if (row_idx !== '0) $display("FAIL reset_r got %0d want 0", row_idx); else passed++;
    total++; if (w_ready !== 1'b0) $display("FAIL reset_w_ready got %b want 0", w_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (cfg_err !== 1'b0) $display("FAIL reset_cfg_err got %b want 0", cfg_err); else passed++;
    total++; if (filter_load !== 1'b1) $display("FAIL reset_filter_load got %b want 1", filter_load); else passed++;
    reset = 1'b0;
  endtask

  // vmode: 0 = w_valid always 1, 1 = alternating 1/0, 2 = random.
  // start_at >= 0 pulses start once after that many beats have been accepted.
  task automatic test_load_run(input int nf, input int nk, input int nr, input int vmode,
                               input int start_at, input logic bc, input string tag);
    int            n;
    int            cyc;
    int            beats;
    bit            seen_done;
    bit            pulsed;
    beat_t         e;
    logic [MF-1:0] one;
    one = MF'(1);
    exp_q.delete();
    for (int f = 0; f < (bc ? 1 : nf); f++)
      for (int k = 0; k < nk; k++)
        for (int r = 0; r < nr; r++) begin
          e.addr = bc ? ((one << nf) - one) : (one << f);
          e.k    = KW'(k);
          e.r    = RW'(r);
          exp_q.push_back(e);
        end
    n = exp_q.size();
    @(negedge clk);
    num_filter = FW'(nf); num_kernel = KW'(nk); num_row = RW'(nr);
    start = 1'b1; w_valid = 1'b0;
`ifdef PE_BCAST_EN
    bcast = bc;
`endif
    @(negedge clk);
    start = 1'b0; cyc = 1; beats = 0; seen_done = 1'b0; pulsed = 1'b0;
    while (!seen_done && cyc <= 4 * n + 20) begin
      if (done === 1'b1) begin
        seen_done = 1'b1;
        total++; if (cfg_err !== 1'b0) $display("FAIL %s done_cfg_err got %b want 0", tag, cfg_err); else passed++;
        total++; if (beats != n) $display("FAIL %s beat_count got %0d want %0d", tag, beats, n); else passed++;
        total++; if (filter_addr !== '0) $display("FAIL %s done_addr got %h want 0", tag, filter_addr); else passed++;
        total++; if (w_ready !== 1'b0 || busy !== 1'b0) $display("FAIL %s done_ready_busy got %b%b want 00", tag, w_ready, busy); else passed++;
        total++; if (filter_load !== 1'b1) $display("FAIL %s done_filter_load got %b want 1", tag, filter_load); else passed++;
        if (vmode == 0) begin
          total++; if (cyc != n + 1) $display("FAIL %s done_cycle got %0d want %0d", tag, cyc, n + 1); else passed++;
        end
        // start during DONE must be ignored, not queued
        w_valid = 1'b0; start = 1'b1;
        num_filter = FW'(1); num_kernel = KW'(1); num_row = RW'(1);
        @(negedge clk);
        start = 1'b0;
        total++; if (done !== 1'b0) $display("FAIL %s done_pulse_width got %b want 0", tag, done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL %s start_in_done got busy %b want 0", tag, busy); else passed++;
      end else begin
        if (exp_q.size() == 0) begin
          total++; $display("FAIL %s extra_load_cycle got busy %b want done", tag, busy);
        end else begin
          total++; if (filter_addr !== exp_q[0].addr) $display("FAIL %s addr beat %0d got %h want %h", tag, beats, filter_addr, exp_q[0].addr); else passed++;
          total++; if (kernel_idx !== exp_q[0].k || row_idx !== exp_q[0].r) $display("FAIL %s idx beat %0d got k%0d r%0d want k%0d r%0d", tag, beats, kernel_idx, row_idx, exp_q[0].k, exp_q[0].r); else passed++;
          total++; if (w_ready !== 1'b1 || busy !== 1'b1 || filter_load !== 1'b0) $display("FAIL %s load_flags got rdy%b busy%b fl%b want 1 1 0", tag, w_ready, busy, filter_load); else passed++;
        end
        start = 1'b0;
        if (start_at >= 0 && !pulsed && beats == start_at) begin
          start = 1'b1; pulsed = 1'b1;
        end
        case (vmode)
          0:       w_valid = 1'b1;
          1:       w_valid = (cyc % 2) == 1;
          default: w_valid = 1'($urandom_range(0, 1));
        endcase
        if (w_valid && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          beats++;
        end
        // count inputs are latched at start; scribbling on them must not matter
        num_filter = FW'($urandom); num_kernel = KW'($urandom); num_row = RW'($urandom);
        @(negedge clk);
        cyc++;
      end
    end
    w_valid = 1'b0; start = 1'b0;
    if (!seen_done) begin
      total++; $display("FAIL %s timeout got no done want done within %0d cycles", tag, 4 * n + 20);
    end
  endtask

  task automatic test_cfg_err(input int nf, input int nk, input int nr, input string tag);
    @(negedge clk);
    num_filter = FW'(nf); num_kernel = KW'(nk); num_row = RW'(nr);
`ifdef PE_BCAST_EN
    bcast = 1'b0;
`endif
    start = 1'b1; w_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (done !== 1'b1 || cfg_err !== 1'b1) $display("FAIL %s err_pulse got done%b err%b want 1 1", tag, done, cfg_err); else passed++;
    total++; if (w_ready !== 1'b0 || busy !== 1'b0) $display("FAIL %s err_ready_busy got %b%b want 00", tag, w_ready, busy); else passed++;
    total++; if (filter_addr !== '0) $display("FAIL %s err_addr got %h want 0", tag, filter_addr); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0 || cfg_err !== 1'b0) $display("FAIL %s err_after got done%b err%b want 0 0", tag, done, cfg_err); else passed++;
    total++; if (w_ready !== 1'b0) $display("FAIL %s err_after_ready got %b want 0", tag, w_ready); else passed++;
    w_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [MF-1:0] one;
    one = MF'(1);
    @(negedge clk);
    num_filter = FW'(32); num_kernel = KW'(4); num_row = RW'(1);
`ifdef PE_BCAST_EN
    bcast = 1'b0;
`endif
    start = 1'b1; w_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1;
    repeat (40) @(negedge clk);
    total++; if (filter_addr !== (one << 10) || kernel_idx !== KW'(0)) $display("FAIL rst_mid beat40 got %h k%0d want %h k0", filter_addr, kernel_idx, one << 10); else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || w_ready !== 1'b0) $display("FAIL rst_mid busy_ready got %b%b want 00", busy, w_ready); else passed++;
    total++; if (filter_addr !== '0) $display("FAIL rst_mid addr got %h want 0", filter_addr); else passed++;
    total++; if (filter_load !== 1'b1) $display("FAIL rst_mid filter_load got %b want 1", filter_load); else passed++;
    reset = 1'b0; w_valid = 1'b0;
    test_load_run(3, 2, 2, 2, -1, 1'b0, "restart");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      test_load_run(int'($urandom_range(1, 16)), int'($urandom_range(1, 8)),
                    int'($urandom_range(1, 8)), 2, -1, 1'b0, "random");
    end
    test_cfg_err(0, 3, 3, "cfg_rand_f0");
    test_cfg_err(int'($urandom_range(1, 64)), int'($urandom_range(9, 15)), 2, "cfg_rand_k");
    test_cfg_err(int'($urandom_range(65, 127)), 1, 1, "cfg_rand_f");
  endtask

  initial begin
    test_reset();
    test_load_run(32, 4, 1, 0, -1, 1'b0, "full_128");
    test_load_run(2, 2, 3, 1, -1, 1'b0, "alternating");
    test_cfg_err(4, 0, 2, "cfg_k0");
    test_cfg_err(65, 2, 2, "cfg_f65");
    test_cfg_err(2, 2, 9, "cfg_r9");
    test_load_run(32, 4, 1, 0, 5, 1'b0, "start_ignored");
    test_reset_midrun();
    test_load_run(64, 8, 1, 0, -1, 1'b0, "max_filters");
    test_load_run(1, 1, 1, 0, -1, 1'b0, "single_beat");
`ifdef PE_BCAST_EN
    test_load_run(8, 2, 2, 0, -1, 1'b1, "bcast");
    test_load_run(64, 1, 3, 2, -1, 1'b1, "bcast_max");
    test_load_run(3, 2, 2, 0, -1, 1'b0, "bcast_off");
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
